// File: rtl/morse_send_char.sv
// Morse transmitter: serialises one character into on/off keying, ending with a char or word gap.
// Define MORSE_SEND_ABORT_EN to add the abort input (cancel a character in flight).
module morse_send_char #(
  parameter int CNT_W   = 16,
  parameter int LEN_W   = 4,
  parameter int MAX_LEN = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ce,
  input  logic               start,
  input  logic [MAX_LEN-1:0] dits_dahs,
  input  logic [LEN_W-1:0]   len,
  input  logic               word_end,
  input  logic [CNT_W-1:0]   dit_time,
  input  logic [CNT_W-1:0]   dah_time,
  input  logic [CNT_W-1:0]   word_time,
`ifdef MORSE_SEND_ABORT_EN
  input  logic               abort,
`endif
  output logic               signal,
  output logic               busy,
  output logic               error,
  output logic               ceo
);

  typedef enum logic [1:0] {S_IDLE, S_MARK, S_GAP, S_END} state_t;

  localparam logic [31:0]    MaxLen = 32'(MAX_LEN);
  localparam logic [CNT_W-1:0] DurOne = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W:0]   CntOne = {{CNT_W{1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0] LenOne = {{(LEN_W-1){1'b0}}, 1'b1};

  state_t             state_q, state_d;
  logic [CNT_W:0]     cnt_q, cnt_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic               we_q, we_d;
  logic               rej_q, rej_d;
  logic [CNT_W-1:0]   dit_q, dit_d, dah_q, dah_d, word_q, word_d;
  logic               sig_q, sig_d, ceo_q, ceo_d, err_q, err_d;

  logic [CNT_W-1:0]   dit_c, dah_c, word_c;
  logic [MAX_LEN-1:0] aligned;
  logic               start_ok;

  function automatic logic [CNT_W-1:0] at_least_one(input logic [CNT_W-1:0] v);
    return (v == '0) ? DurOne : v;
  endfunction

  function automatic logic [CNT_W:0] mark_load(input logic is_dah,
                                               input logic [CNT_W-1:0] dit,
                                               input logic [CNT_W-1:0] dah);
    return {1'b0, (is_dah ? dah : dit)} - CntOne;
  endfunction

  always_comb begin
    dit_c  = at_least_one(dit_time);
    dah_c  = at_least_one(dah_time);
    word_c = at_least_one(word_time);
    // Left-justify the pattern so the next element to send is always the MSB.
    aligned = dits_dahs << (MaxLen - 32'(len));
`ifdef MORSE_SEND_ABORT_EN
    start_ok = start & ~abort;
`else
    start_ok = start;
`endif

    state_d = state_q;
    cnt_d   = cnt_q;
    pat_d   = pat_q;
    rem_d   = rem_q;
    we_d    = we_q;
    rej_d   = rej_q;
    dit_d   = dit_q;
    dah_d   = dah_q;
    word_d  = word_q;
    sig_d   = sig_q;
    ceo_d   = 1'b0;
    err_d   = 1'b0;

    if (ce) begin
      unique case (state_q)
        S_IDLE: begin
          if (start_ok) begin
            dit_d  = dit_c;
            dah_d  = dah_c;
            word_d = word_c;
            we_d   = word_end;
            rej_d  = 1'b0;
            if (32'(len) > MaxLen) begin
              rej_d   = 1'b1;
              state_d = S_END;
              cnt_d   = '0;
            end else if (len == '0) begin
              state_d = S_END;
              cnt_d   = word_end ? {1'b0, word_c} : '0;
            end else begin
              state_d = S_MARK;
              sig_d   = 1'b1;
              cnt_d   = mark_load(aligned[MAX_LEN-1], dit_c, dah_c);
              pat_d   = aligned << 1;
              rem_d   = len - LenOne;
            end
          end
        end
        S_MARK: begin
          if (cnt_q == '0) begin
            sig_d = 1'b0;
            if (rem_q == '0) begin
              // Trailing gap is base+1 ticks, so the load value is the base itself.
              state_d = S_END;
              cnt_d   = we_q ? {1'b0, word_q} : {1'b0, dah_q};
            end else begin
              state_d = S_GAP;
              cnt_d   = {1'b0, dit_q} - CntOne;
            end
          end else begin
            cnt_d = cnt_q - CntOne;
          end
        end
        S_GAP: begin
          if (cnt_q == '0) begin
            state_d = S_MARK;
            sig_d   = 1'b1;
            cnt_d   = mark_load(pat_q[MAX_LEN-1], dit_q, dah_q);
            pat_d   = pat_q << 1;
            rem_d   = rem_q - LenOne;
          end else begin
            cnt_d = cnt_q - CntOne;
          end
        end
        S_END: begin
          if (cnt_q == '0) begin
            state_d = S_IDLE;
            ceo_d   = 1'b1;
            err_d   = rej_q;
          end else begin
            cnt_d = cnt_q - CntOne;
          end
        end
        default: state_d = S_IDLE;
      endcase

`ifdef MORSE_SEND_ABORT_EN
      if (abort && state_q != S_IDLE) begin
        state_d = S_IDLE;
        sig_d   = 1'b0;
        ceo_d   = 1'b1;
        err_d   = 1'b1;
        cnt_d   = '0;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pat_q   <= '0;
      rem_q   <= '0;
      we_q    <= 1'b0;
      rej_q   <= 1'b0;
      dit_q   <= '0;
      dah_q   <= '0;
      word_q  <= '0;
      sig_q   <= 1'b0;
      ceo_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pat_q   <= pat_d;
      rem_q   <= rem_d;
      we_q    <= we_d;
      rej_q   <= rej_d;
      dit_q   <= dit_d;
      dah_q   <= dah_d;
      word_q  <= word_d;
      sig_q   <= sig_d;
      ceo_q   <= ceo_d;
      err_q   <= err_d;
    end
  end

  assign signal = sig_q;
  assign busy   = (state_q != S_IDLE);
  assign error  = err_q;
  assign ceo    = ceo_q;

endmodule

// File: tb/tb_morse_send_char.sv
// Directed bench for morse_send_char: records mark/space run lengths and compares with hand-derived values.
module tb_morse_send_char;
  logic        clk = 1'b0;
  logic        rst, ce, start, word_end;
  logic [7:0]  dits_dahs;
  logic [3:0]  len;
  logic [15:0] dit_time, dah_time, word_time;
  logic        signal, busy, error, ceo;
`ifdef MORSE_SEND_ABORT_EN
  logic        abort;
  int          abort_at_cyc = -1;
`endif

  morse_send_char #(.CNT_W(16), .LEN_W(4), .MAX_LEN(8)) dut (
    .clk(clk), .rst(rst), .ce(ce), .start(start),
    .dits_dahs(dits_dahs), .len(len), .word_end(word_end),
    .dit_time(dit_time), .dah_time(dah_time), .word_time(word_time),
`ifdef MORSE_SEND_ABORT_EN
    .abort(abort),
`endif
    .signal(signal), .busy(busy), .error(error), .ceo(ceo)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int runs[$];
  int exp_q[$];
  bit ceo_seen;
  logic err_at_ceo, busy_at_ceo;
  logic [15:0] t_dit = 16'd10, t_dah = 16'd30, t_word = 16'd70;

  // Present a character with start=1 for one edge, then scramble the inputs.
  task automatic do_start(input logic [7:0] pat, input logic [3:0] l, input logic we);
    dits_dahs = pat; len = l; word_end = we;
    dit_time = t_dit; dah_time = t_dah; word_time = t_word;
    ce = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dits_dahs = ~pat; len = l ^ 4'd3; word_end = ~we;
    dit_time = 16'd3; dah_time = 16'd5; word_time = 16'd7;
  endtask

  // Run-length encode signal (+N high, -N low) per clk until ceo is seen.
  task automatic record(input bit toggle, input int inject_at);
    int last;
    runs.delete();
    ceo_seen = 1'b0; err_at_ceo = 1'bx; busy_at_ceo = 1'bx;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      if (ceo === 1'b1) begin
        ceo_seen = 1'b1; err_at_ceo = error; busy_at_ceo = busy;
        break;
      end
      last = runs.size() - 1;
      if (last >= 0 && ((runs[last] > 0) == (signal === 1'b1))) begin
        if (runs[last] > 0) runs[last] = runs[last] + 1;
        else runs[last] = runs[last] - 1;
      end else begin
        runs.push_back((signal === 1'b1) ? 1 : -1);
      end
      if (toggle) ce = ~ce;
      start = (cyc == inject_at || cyc == inject_at + 1);
`ifdef MORSE_SEND_ABORT_EN
      abort = (cyc == abort_at_cyc);
`endif
      @(posedge clk); #1;
    end
    start = 1'b0;
    ce = 1'b1;
`ifdef MORSE_SEND_ABORT_EN
    abort = 1'b0;
`endif
  endtask

  task automatic test_reset;
    rst = 1'b1; ce = 1'b1; start = 1'b0; dits_dahs = '0; len = '0; word_end = 1'b0;
    dit_time = t_dit; dah_time = t_dah; word_time = t_word;
`ifdef MORSE_SEND_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (signal !== 1'b0) begin n_fail++; $display("FAIL reset_signal got %b want 0", signal); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL reset_error got %b want 0", error); end
    n_checks++; if (ceo !== 1'b0) begin n_fail++; $display("FAIL reset_ceo got %b want 0", ceo); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_char_gap;
    do_start(8'b0001_1010, 4'd5, 1'b0);
    record(1'b0, 40);
    exp_q = '{30, -10, 30, -10, 10, -10, 30, -10, 10, -31};
    n_checks++;
    if (runs.size() != exp_q.size()) begin
      n_fail++; $display("FAIL char_runs_count got %0d want %0d", runs.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      n_checks++;
      if (runs[i] != exp_q[i]) begin n_fail++; $display("FAIL char_run[%0d] got %0d want %0d", i, runs[i], exp_q[i]); end
    end
    n_checks++; if (ceo_seen !== 1'b1) begin n_fail++; $display("FAIL char_ceo got %b want 1", ceo_seen); end
    n_checks++; if (err_at_ceo !== 1'b0) begin n_fail++; $display("FAIL char_error got %b want 0", err_at_ceo); end
    n_checks++; if (busy_at_ceo !== 1'b0) begin n_fail++; $display("FAIL char_busy_at_ceo got %b want 0", busy_at_ceo); end
    @(posedge clk); #1;
    n_checks++; if (ceo !== 1'b0) begin n_fail++; $display("FAIL char_ceo_width got %b want 0", ceo); end
  endtask

  task automatic test_word_gap;
    do_start(8'b0000_0000, 4'd3, 1'b1);
    record(1'b0, -10);
    exp_q = '{10, -10, 10, -10, 10, -71};
    n_checks++;
    if (runs.size() != exp_q.size()) begin
      n_fail++; $display("FAIL word_runs_count got %0d want %0d", runs.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      n_checks++;
      if (runs[i] != exp_q[i]) begin n_fail++; $display("FAIL word_run[%0d] got %0d want %0d", i, runs[i], exp_q[i]); end
    end
    n_checks++; if (ceo_seen !== 1'b1) begin n_fail++; $display("FAIL word_ceo got %b want 1", ceo_seen); end
  endtask

  task automatic test_len_edges;
    // len=0 with word gap, len=0 without, len=MAX_LEN+1 rejected
    do_start(8'hA5, 4'd0, 1'b1);
    record(1'b0, -10);
    n_checks++; if (runs.size() != 1 || runs[0] != -71) begin n_fail++; $display("FAIL len0_word got %0d runs first %0d want 1 run -71", runs.size(), runs.size() > 0 ? runs[0] : 0); end
    n_checks++; if (err_at_ceo !== 1'b0) begin n_fail++; $display("FAIL len0_word_error got %b want 0", err_at_ceo); end
    do_start(8'hA5, 4'd0, 1'b0);
    record(1'b0, -10);
    n_checks++; if (runs.size() != 1 || runs[0] != -1) begin n_fail++; $display("FAIL len0_char got %0d runs first %0d want 1 run -1", runs.size(), runs.size() > 0 ? runs[0] : 0); end
    do_start(8'hFF, 4'd9, 1'b0);
    record(1'b0, -10);
    n_checks++; if (runs.size() != 1 || runs[0] != -1) begin n_fail++; $display("FAIL len_over got %0d runs first %0d want 1 run -1", runs.size(), runs.size() > 0 ? runs[0] : 0); end
    n_checks++; if (err_at_ceo !== 1'b1) begin n_fail++; $display("FAIL len_over_error got %b want 1", err_at_ceo); end
  endtask

  task automatic test_zero_durations;
    t_dit = 16'd0;
    do_start(8'b0000_0000, 4'd1, 1'b0);
    record(1'b0, -10);
    n_checks++; if (runs.size() != 2 || runs[0] != 1 || runs[1] != -31) begin n_fail++; $display("FAIL zero_dit got %0d runs first %0d want {1,-31}", runs.size(), runs.size() > 0 ? runs[0] : 0); end
    t_dit = 16'd10; t_word = 16'd0;
    do_start(8'h00, 4'd0, 1'b1);
    record(1'b0, -10);
    n_checks++; if (runs.size() != 1 || runs[0] != -2) begin n_fail++; $display("FAIL zero_word got %0d runs first %0d want {-2}", runs.size(), runs.size() > 0 ? runs[0] : 0); end
    t_word = 16'd70;
  endtask

  task automatic test_ce_toggle;
    do_start(8'b0000_0010, 4'd2, 1'b0);
    record(1'b1, 21);
    exp_q = '{60, -20, 20, -62};
    n_checks++;
    if (runs.size() != exp_q.size()) begin
      n_fail++; $display("FAIL ce_runs_count got %0d want %0d", runs.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      n_checks++;
      if (runs[i] != exp_q[i]) begin n_fail++; $display("FAIL ce_run[%0d] got %0d want %0d", i, runs[i], exp_q[i]); end
    end
    n_checks++; if (ceo_seen !== 1'b1) begin n_fail++; $display("FAIL ce_ceo got %b want 1", ceo_seen); end
    @(posedge clk); #1;
    n_checks++; if (ceo !== 1'b0) begin n_fail++; $display("FAIL ce_ceo_width got %b want 0", ceo); end
  endtask

  task automatic test_back_to_back;
    do_start(8'b0000_0000, 4'd1, 1'b0);
    record(1'b0, -10);
    n_checks++; if (runs.size() != 2 || runs[0] != 10 || runs[1] != -31) begin n_fail++; $display("FAIL b2b_first got %0d runs first %0d want {10,-31}", runs.size(), runs.size() > 0 ? runs[0] : 0); end
    do_start(8'b0000_0001, 4'd2, 1'b0);
    n_checks++; if (busy !== 1'b1 || signal !== 1'b1) begin n_fail++; $display("FAIL b2b_accept got busy=%b signal=%b want 1 1", busy, signal); end
    record(1'b0, -10);
    exp_q = '{10, -10, 30, -31};
    n_checks++;
    if (runs.size() != exp_q.size()) begin
      n_fail++; $display("FAIL b2b_runs_count got %0d want %0d", runs.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      n_checks++;
      if (runs[i] != exp_q[i]) begin n_fail++; $display("FAIL b2b_run[%0d] got %0d want %0d", i, runs[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid;
    do_start(8'b0000_0001, 4'd1, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    n_checks++; if (signal !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre got %b want 1", signal); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (signal !== 1'b0) begin n_fail++; $display("FAIL rstmid_signal got %b want 0", signal); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %b want 0", busy); end
    #2 rst = 1'b0;
    @(posedge clk); #1;
    do_start(8'b0000_0000, 4'd1, 1'b0);
    record(1'b0, -10);
    n_checks++; if (runs.size() != 2 || runs[0] != 10 || runs[1] != -31) begin n_fail++; $display("FAIL rstmid_after got %0d runs first %0d want {10,-31}", runs.size(), runs.size() > 0 ? runs[0] : 0); end
  endtask

`ifdef MORSE_SEND_ABORT_EN
  task automatic test_abort;
    abort_at_cyc = 25;
    do_start(8'b0000_0100, 4'd4, 1'b0);
    record(1'b0, -10);
    abort_at_cyc = -1;
    exp_q = '{10, -10, 6};
    n_checks++;
    if (runs.size() != exp_q.size()) begin
      n_fail++; $display("FAIL abort_runs_count got %0d want %0d", runs.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      n_checks++;
      if (runs[i] != exp_q[i]) begin n_fail++; $display("FAIL abort_run[%0d] got %0d want %0d", i, runs[i], exp_q[i]); end
    end
    n_checks++; if (err_at_ceo !== 1'b1) begin n_fail++; $display("FAIL abort_error got %b want 1", err_at_ceo); end
    n_checks++; if (signal !== 1'b0) begin n_fail++; $display("FAIL abort_signal got %b want 0", signal); end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_char_gap;
    test_word_gap;
    test_len_edges;
    test_zero_durations;
    test_ce_toggle;
    test_back_to_back;
    test_reset_mid;
`ifdef MORSE_SEND_ABORT_EN
    test_abort;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
